// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues sequential fetches over a valid/ready port and
// buffers returned words with their PC in an in-order queue feeding decode.
module if_fetch_queue #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               INC      = 4,
  parameter int               DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_SRC,
  input  logic [XLEN-1:0] PC_IN,
  output logic            IMEM_REQ_VALID,
  output logic [XLEN-1:0] IMEM_REQ_ADDR,
  input  logic            IMEM_REQ_READY,
  input  logic            IMEM_RSP_VALID,
  input  logic [31:0]     IMEM_RSP_DATA,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic [31:0]     INSTR_OUT,
  output logic [XLEN-1:0] PC_OUT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INC);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic [CW:0] credits_used;
  logic        req_fire;
  logic        keep;
  logic        pop;

  // Queue entries plus requests in flight never exceed DEPTH, so a kept
  // response always has a free slot waiting for it.
  assign credits_used   = {1'b0, count} + {1'b0, outstanding};
  assign IMEM_REQ_VALID = rst & ~PC_SRC & (credits_used < (CW+1)'(DEPTH));
  assign IMEM_REQ_ADDR  = fetch_pc;
  assign req_fire       = IMEM_REQ_VALID & IMEM_REQ_READY;

  assign keep        = IMEM_RSP_VALID & ~PC_SRC & (drop == '0);
  assign INSTR_VALID = (count != '0) & ~PC_SRC;
  assign pop         = INSTR_VALID & INSTR_READY;
  assign INSTR_OUT   = instr_q[head];
  assign PC_OUT      = pc_q[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(IMEM_RSP_VALID);
      if (PC_SRC) begin
        // Everything still owed after this cycle belongs to the old path.
        fetch_pc <= PC_IN;
        rsp_pc   <= PC_IN;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop     <= outstanding - CW'(IMEM_RSP_VALID);
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + STEP;
        if (IMEM_RSP_VALID && (drop != '0))
          drop <= drop - CW'(1);
        if (keep) begin
          rsp_pc <= rsp_pc + STEP;
          tail   <= tail + AW'(1);
        end
        if (pop)
          head <= head + AW'(1);
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && keep) begin
      instr_q[tail] <= IMEM_RSP_DATA;
      pc_q[tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a latency-configurable memory model
// that answers each fetch with address + 0x100.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] pc_in;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int errors = 0;
  int checks = 0;
  int lat    = 1;

  if_fetch_queue #(.XLEN(32), .RESET_PC(32'h0), .INC(4), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_SRC         (pc_src),
    .PC_IN          (pc_in),
    .IMEM_REQ_VALID (imem_req_valid),
    .IMEM_REQ_ADDR  (imem_req_addr),
    .IMEM_REQ_READY (imem_req_ready),
    .IMEM_RSP_VALID (imem_rsp_valid),
    .IMEM_RSP_DATA  (imem_rsp_data),
    .INSTR_VALID    (instr_valid),
    .INSTR_READY    (instr_ready),
    .INSTR_OUT      (instr_out),
    .PC_OUT         (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  logic        smp_fire = 1'b0;
  logic        smp_rsp  = 1'b0;
  logic [31:0] smp_addr = '0;

  always @(negedge clk) begin
    smp_fire = rst & imem_req_valid & imem_req_ready;
    smp_addr = imem_req_addr;
    smp_rsp  = imem_rsp_valid;
  end

  // In-order memory: a request accepted in cycle t answers in cycle t+lat.
  // Reset forgets every pending request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (smp_rsp && pend.size() > 0)
        void'(pend.pop_front());
      if (smp_fire)
        pend.push_back('{smp_addr, cyc + lat});
      cyc = cyc + 1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= pend[0].addr + 32'h100;
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic req_rdy, input logic ins_rdy, input int latency);
    imem_req_ready = req_rdy;
    instr_ready    = ins_rdy;
    lat            = latency;
    pc_src         = 1'b0;
  endtask

  // Returns at the start of the first cycle with rst released.
  task automatic reset_dut();
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_fire;
    logic [31:0] fired [4];

    rst            = 1'b0;
    pc_src         = 1'b0;
    pc_in          = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #2;
    check_output("reset_req_valid", imem_req_valid, 0);
    check_output("reset_instr_valid", instr_valid, 0);

    // Stream from RESET_PC with a 1-cycle memory.
    apply_stimulus(1'b1, 1'b1, 1);
    reset_dut();
    mid();
    check_output("stream_c0_req_valid", imem_req_valid, 1);
    check_output("stream_c0_req_addr", imem_req_addr, 32'h0);
    check_output("stream_c0_instr_valid", instr_valid, 0);
    step();
    mid();
    check_output("stream_c1_instr_valid", instr_valid, 0);
    check_output("stream_c1_req_addr", imem_req_addr, 32'h4);
    step();
    for (int i = 0; i < 3; i++) begin
      mid();
      check_output($sformatf("stream_valid_%0d", i), instr_valid, 1);
      check_output($sformatf("stream_instr_%0d", i), instr_out, 32'h100 + 32'(4 * i));
      check_output($sformatf("stream_pc_%0d", i), pc_out, 32'(4 * i));
      step();
    end

    // Decode backpressure: four credits, then issue stops.
    apply_stimulus(1'b1, 1'b0, 1);
    reset_dut();
    n_fire = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (imem_req_valid && imem_req_ready) begin
        if (n_fire < 4) fired[n_fire] = imem_req_addr;
        n_fire++;
      end
      if (i < 9) step();
    end
    check_output("bp_num_requests", 32'(n_fire), 32'd4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("bp_req_addr_%0d", i), fired[i], 32'(4 * i));
    check_output("bp_req_valid_idle", imem_req_valid, 0);
    check_output("bp_queue_count", 32'(dut.count), 32'd4);
    step();
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      if (i == 0) check_output("bp_no_issue_while_full", imem_req_valid, 0);
      if (i == 1) begin
        check_output("bp_resume_valid", imem_req_valid, 1);
        check_output("bp_resume_addr", imem_req_addr, 32'h10);
      end
      check_output($sformatf("bp_drain_valid_%0d", i), instr_valid, 1);
      check_output($sformatf("bp_drain_pc_%0d", i), pc_out, 32'(4 * i));
      check_output($sformatf("bp_drain_instr_%0d", i), instr_out, 32'h100 + 32'(4 * i));
      step();
    end

    // Redirect with two stale responses in flight (3-cycle memory).
    apply_stimulus(1'b1, 1'b1, 3);
    reset_dut();
    step();
    step();
    pc_src = 1'b1;
    pc_in  = 32'h200;
    mid();
    check_output("redir_req_valid_low", imem_req_valid, 0);
    check_output("redir_instr_valid_low", instr_valid, 0);
    step();
    pc_src = 1'b0;
    mid();
    check_output("redir_req_valid", imem_req_valid, 1);
    check_output("redir_req_addr", imem_req_addr, 32'h200);
    check_output("redir_drop", 32'(dut.drop), 32'd2);
    check_output("redir_queue_empty", 32'(dut.count), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      mid();
      check_output($sformatf("redir_stale_hidden_%0d", i), instr_valid, 0);
      step();
    end
    mid();
    check_output("redir_first_valid", instr_valid, 1);
    check_output("redir_first_pc", pc_out, 32'h200);
    check_output("redir_first_instr", instr_out, 32'h300);

    // Redirect in the same cycle as a response and a ready decode (2-cycle memory).
    apply_stimulus(1'b1, 1'b1, 2);
    reset_dut();
    step();
    mid();
    check_output("coin_pre_instr_valid", instr_valid, 0);
    step();
    step();
    pc_src = 1'b1;
    pc_in  = 32'h400;
    mid();
    check_output("coin_no_pop_valid", instr_valid, 0);
    check_output("coin_req_valid_low", imem_req_valid, 0);
    step();
    pc_src = 1'b0;
    mid();
    check_output("coin_drop", 32'(dut.drop), 32'd1);
    check_output("coin_outstanding", 32'(dut.outstanding), 32'd1);
    check_output("coin_queue_empty", 32'(dut.count), 32'd0);
    check_output("coin_req_addr", imem_req_addr, 32'h400);
    step();
    for (int i = 0; i < 2; i++) begin
      mid();
      check_output($sformatf("coin_stale_hidden_%0d", i), instr_valid, 0);
      step();
    end
    mid();
    check_output("coin_first_valid", instr_valid, 1);
    check_output("coin_first_pc", pc_out, 32'h400);
    check_output("coin_first_instr", instr_out, 32'h500);

    // Memory stall: request held steady until accepted.
    apply_stimulus(1'b0, 1'b1, 1);
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      mid();
      check_output($sformatf("stall_valid_%0d", i), imem_req_valid, 1);
      check_output($sformatf("stall_addr_%0d", i), imem_req_addr, 32'h0);
      step();
    end
    imem_req_ready = 1'b1;
    mid();
    check_output("stall_accept_addr", imem_req_addr, 32'h0);
    step();
    mid();
    check_output("stall_next_valid", imem_req_valid, 1);
    check_output("stall_next_addr", imem_req_addr, 32'h4);

    // Asynchronous reset with three queued instructions.
    apply_stimulus(1'b1, 1'b0, 1);
    reset_dut();
    repeat (5) step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    check_output("areset_pre_count", 32'(dut.count), 32'd3);
    check_output("areset_pre_instr_valid", instr_valid, 1);
    check_output("areset_pre_req_valid", imem_req_valid, 1);
    check_output("areset_pre_req_addr", imem_req_addr, 32'h10);
    rst = 1'b0;
    #1;
    check_output("areset_instr_valid_low", instr_valid, 0);
    check_output("areset_req_valid_low", imem_req_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mid();
    check_output("areset_restart_valid", imem_req_valid, 1);
    check_output("areset_restart_addr", imem_req_addr, 32'h0);
    check_output("areset_restart_instr_valid", instr_valid, 0);
    step();
    step();
    mid();
    check_output("areset_first_valid", instr_valid, 1);
    check_output("areset_first_pc", pc_out, 32'h0);
    check_output("areset_first_instr", instr_out, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
